seq_alu: RTL and testbench

Parametrised multi-cycle ALU, successor to the 32-bit combinational 3-bit-op ALU. Supports a wider 4-bit opcode set: the original add/sub/and/or/srl/sra plus sll, slt, sltu, xor, and iterative unsigned multiply, divide and remainder. A start/busy/done handshake lets the datapath stall on multi-cycle ops. The result is registered and held until the next completion. It sits between the operand registers and the writeback mux of the multi-cycle CPU.

---
 rtl/seq_alu_if.sv | 24 ++
 rtl/seq_alu.sv | 143 ++++++++++++++
 tb/tb_seq_alu.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Operand, opcode and result bundle with the start/busy/done handshake of seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] C;
  logic             zero;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, ALUOp,
    input  C, zero, overflow, busy, done
  );

  modport slave (
    input  start, A, B, ALUOp,
    output C, zero, overflow, busy, done
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative unsigned
// multiply (shift-add) and divide/remainder (restoring), behind start/busy/done.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_c;
  logic             r_zero;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_acc;
  logic             r_isQuo;
  logic [SHW-1:0]   r_cnt;

  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  logic [WIDTH-1:0] w_result;
  logic             w_ovf;
  logic [WIDTH:0]   w_remSh;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_final;

  assign w_sh  = bus.B[SHW-1:0];
  assign w_sum = bus.A + bus.B;
  assign w_dif = bus.A - bus.B;

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (bus.ALUOp)
      4'd0: begin
        w_result = w_sum;
        w_ovf    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      4'd1: begin
        w_result = w_dif;
        w_ovf    = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_dif[WIDTH-1] != bus.A[WIDTH-1]);
      end
      4'd2:    w_result = bus.A & bus.B;
      4'd3:    w_result = bus.A | bus.B;
      4'd4:    w_result = bus.A >> w_sh;
      4'd5:    w_result = $signed(bus.A) >>> w_sh;
      4'd6:    w_result = bus.A << w_sh;
      4'd7:    w_result = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      4'd8:    w_result = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      4'd9:    w_result = bus.A ^ bus.B;
      default: w_result = '0;
    endcase
  end

  // Divider: r_acc is the partial remainder, r_opA shifts the dividend out
  // at the top while quotient bits enter at the bottom.
  assign w_remSh = {r_acc, r_opA[WIDTH-1]};
  assign w_trial = w_remSh - {1'b0, r_opB};
  assign w_final = r_isQuo ? r_opA : r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_c     <= '0;
      r_zero  <= 1'b1;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_opA   <= '0;
      r_opB   <= '0;
      r_acc   <= '0;
      r_isQuo <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_opA   <= bus.A;
            r_opB   <= bus.B;
            r_acc   <= '0;
            r_cnt   <= SHW'(WIDTH - 1);
            r_isQuo <= (bus.ALUOp == 4'd11);
            if (bus.ALUOp == 4'd10) begin
              r_state <= MUL;
              r_busy  <= 1'b1;
            end else if ((bus.ALUOp == 4'd11) || (bus.ALUOp == 4'd12)) begin
              r_state <= DIV;
              r_busy  <= 1'b1;
            end else begin
              r_c    <= w_result;
              r_zero <= (w_result == '0);
              r_ovf  <= w_ovf;
              r_done <= 1'b1;
            end
          end
        end
        MUL: begin
          if (r_opB[0]) begin
            r_acc <= r_acc + r_opA;
          end
          r_opA <= r_opA << 1;
          r_opB <= r_opB >> 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= FIN;
          end
        end
        DIV: begin
          r_opA <= {r_opA[WIDTH-2:0], ~w_trial[WIDTH]};
          r_acc <= w_trial[WIDTH] ? w_remSh[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          r_c     <= w_final;
          r_zero  <= (w_final == '0);
          r_ovf   <= 1'b0;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.C        = r_c;
  assign bus.zero     = r_zero;
  assign bus.overflow = r_ovf;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=32 and WIDTH=8: directed vector table,
// hand-written handshake sequences and randomized ops against an arithmetic model.
module tb_seq_alu;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) b32 ();
  seq_alu_if #(.WIDTH(8))  b8 ();

  seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

  int passCnt  = 0;
  int totalCnt = 0;

  typedef struct {
    int          w;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] expC;
    bit          expOvf;
    string       name;
  } vec_t;

  vec_t vecs [20];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    totalCnt++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end else begin
      passCnt++;
    end
  endtask

  task automatic drive(input int w, input bit s, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w == 32) begin
      b32.start = s; b32.ALUOp = op; b32.A = a[31:0]; b32.B = b[31:0];
    end else begin
      b8.start = s; b8.ALUOp = op; b8.A = a[7:0]; b8.B = b[7:0];
    end
  endtask

  function automatic logic [63:0] getC(input int w);
    return (w == 32) ? {32'b0, b32.C} : {56'b0, b8.C};
  endfunction

  function automatic bit getDone(input int w);
    return (w == 32) ? b32.done : b8.done;
  endfunction

  function automatic bit getBusy(input int w);
    return (w == 32) ? b32.busy : b8.busy;
  endfunction

  function automatic bit getZero(input int w);
    return (w == 32) ? b32.zero : b8.zero;
  endfunction

  function automatic bit getOvf(input int w);
    return (w == 32) ? b32.overflow : b8.overflow;
  endfunction

  function automatic bit isMulti(input logic [3:0] op);
    return (op == 4'd10) || (op == 4'd11) || (op == 4'd12);
  endfunction

  // Reference: plain integer arithmetic on sign-extended / masked 64-bit values.
  function automatic void refModel(input int w, input logic [3:0] op,
                                   input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] c, output bit ovf);
    logic [63:0] mask;
    longint      sa, sb, maxS, minS;
    int          sh;
    mask = (64'd1 << w) - 64'd1;
    sa   = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    maxS = longint'((64'd1 << (w - 1)) - 64'd1);
    minS = -maxS - 1;
    sh   = int'(b % 64'(w));
    c    = 64'd0;
    ovf  = 1'b0;
    case (op)
      4'd0: begin c = (a + b) & mask; ovf = ((sa + sb) > maxS) || ((sa + sb) < minS); end
      4'd1: begin c = (a - b) & mask; ovf = ((sa - sb) > maxS) || ((sa - sb) < minS); end
      4'd2:  c = a & b;
      4'd3:  c = a | b;
      4'd4:  c = a >> sh;
      4'd5:  c = 64'(sa >>> sh) & mask;
      4'd6:  c = (a << sh) & mask;
      4'd7:  c = (sa < sb) ? 64'd1 : 64'd0;
      4'd8:  c = (a < b) ? 64'd1 : 64'd0;
      4'd9:  c = a ^ b;
      4'd10: c = (a * b) & mask;
      4'd11: c = (b == 64'd0) ? mask : a / b;
      4'd12: c = (b == 64'd0) ? a : a % b;
      default: c = 64'd0;
    endcase
  endfunction

  // One accepted op; operands are scrambled right after acceptance.
  task automatic applyStimulus(input int w, input logic [3:0] op,
                               input logic [63:0] a, input logic [63:0] b,
                               output logic [63:0] c, output bit z, output bit o,
                               output int lat, output int busyCyc);
    @(negedge clk);
    drive(w, 1'b1, op, a, b);
    @(posedge clk);
    @(negedge clk);
    drive(w, 1'b0, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    lat     = 0;
    busyCyc = 0;
    while (!getDone(w) && lat < 200) begin
      if (getBusy(w)) busyCyc++;
      @(negedge clk);
      lat++;
    end
    c = getC(w);
    z = getZero(w);
    o = getOvf(w);
  endtask

  initial begin
    logic [63:0] c, expC, a, b;
    bit          z, o, expOvf;
    int          lat, busyCyc, expLat, cChanged, doneAt, doneCnt;
    logic [3:0]  op;
    logic [36:0] donePat, expPat;
    logic [63:0] resQ[$];
    logic [63:0] b2bExp[4];

    vecs = '{
      '{32, 4'd0,  64'h7FFFFFFF, 64'h1,        64'h80000000, 1'b1, "add_ovf"},
      '{32, 4'd0,  64'hFFFFFFFF, 64'h1,        64'h0,        1'b0, "add_wrap"},
      '{32, 4'd1,  64'h5,        64'h5,        64'h0,        1'b0, "sub_zero"},
      '{32, 4'd1,  64'h80000000, 64'h1,        64'h7FFFFFFF, 1'b1, "sub_ovf"},
      '{32, 4'd2,  64'hF0F0F0F0, 64'h0FF00FF0, 64'h00F000F0, 1'b0, "and"},
      '{32, 4'd3,  64'hF0F0F0F0, 64'h0F0F0000, 64'hFFFFF0F0, 1'b0, "or"},
      '{32, 4'd4,  64'h80000000, 64'h21,       64'h40000000, 1'b0, "srl_mod"},
      '{32, 4'd5,  64'h80000000, 64'h24,       64'hF8000000, 1'b0, "sra"},
      '{32, 4'd6,  64'h1,        64'h1F,       64'h80000000, 1'b0, "sll"},
      '{32, 4'd7,  64'hFFFFFFFF, 64'h1,        64'h1,        1'b0, "slt"},
      '{32, 4'd8,  64'hFFFFFFFF, 64'h1,        64'h0,        1'b0, "sltu"},
      '{32, 4'd9,  64'hAAAA5555, 64'hFFFF0000, 64'h55555555, 1'b0, "xor"},
      '{32, 4'd14, 64'h5,        64'h3,        64'h0,        1'b0, "reserved"},
      '{32, 4'd10, 64'hFFFF,     64'h10001,    64'hFFFFFFFF, 1'b0, "mulu"},
      '{32, 4'd11, 64'd100,      64'd7,        64'd14,       1'b0, "divu"},
      '{32, 4'd12, 64'd100,      64'd7,        64'd2,        1'b0, "remu"},
      '{32, 4'd11, 64'h12345678, 64'h0,        64'hFFFFFFFF, 1'b0, "divu_zero"},
      '{32, 4'd12, 64'd9,        64'h0,        64'd9,        1'b0, "remu_zero"},
      '{8,  4'd6,  64'h81,       64'h09,       64'h02,       1'b0, "sll8"},
      '{8,  4'd10, 64'd15,       64'd17,       64'hFF,       1'b0, "mulu8"}
    };

    drive(32, 1'b0, 4'd0, 64'd0, 64'd0);
    drive(8,  1'b0, 4'd0, 64'd0, 64'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int w;
      w = (i == 0) ? 32 : 8;
      checkOutput($sformatf("rst_C_w%0d", w),    getC(w),    64'd0);
      checkOutput($sformatf("rst_zero_w%0d", w), 64'(getZero(w)), 64'd1);
      checkOutput($sformatf("rst_ovf_w%0d", w),  64'(getOvf(w)),  64'd0);
      checkOutput($sformatf("rst_busy_w%0d", w), 64'(getBusy(w)), 64'd0);
      checkOutput($sformatf("rst_done_w%0d", w), 64'(getDone(w)), 64'd0);
    end
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b, c, z, o, lat, busyCyc);
      expLat = isMulti(vecs[i].op) ? vecs[i].w + 1 : 0;
      checkOutput({vecs[i].name, "_C"},    c,           vecs[i].expC);
      checkOutput({vecs[i].name, "_zero"}, 64'(z),      64'(vecs[i].expC == 64'd0));
      checkOutput({vecs[i].name, "_ovf"},  64'(o),      64'(vecs[i].expOvf));
      checkOutput({vecs[i].name, "_lat"},  64'(lat),    64'(expLat));
      checkOutput({vecs[i].name, "_busy"}, 64'(busyCyc), 64'(expLat));
    end

    // Start pulses while busy must be ignored and C must hold until done
    applyStimulus(32, 4'd0, 64'd3, 64'd4, c, z, o, lat, busyCyc);
    checkOutput("hold_pre_C", c, 64'd7);
    @(negedge clk);
    drive(32, 1'b1, 4'd10, 64'h1234, 64'h10);
    @(posedge clk);
    cChanged = 0;
    doneAt   = -1;
    busyCyc  = 0;
    for (int k = 0; k < 60 && doneAt < 0; k++) begin
      @(negedge clk);
      if (b32.done) begin
        doneAt = k;
        drive(32, 1'b0, 4'd0, 64'd0, 64'd0);
      end else begin
        if (b32.C !== 32'h7) cChanged++;
        if (b32.busy) busyCyc++;
        drive(32, bit'(k & 1), 4'd0, 64'h1, 64'h1);
      end
    end
    checkOutput("hold_C_changes", 64'(cChanged), 64'd0);
    checkOutput("hold_done_at",   64'(doneAt),   64'd33);
    checkOutput("hold_busy_cyc",  64'(busyCyc),  64'd33);
    checkOutput("hold_result",    getC(32),      64'h12340);
    @(negedge clk);
    checkOutput("hold_done_pulse", 64'(b32.done), 64'd0);

    // Back-to-back with start held high: add, xor, mulu, and
    b2bExp = '{64'h30, 64'hFF00, 64'h123400, 64'h0F000F00};
    resQ.delete();
    @(negedge clk);
    drive(32, 1'b1, 4'd0, 64'h10, 64'h20);
    for (int i = 0; i < 37; i++) begin
      @(posedge clk);
      @(negedge clk);
      donePat[i] = b32.done;
      if (b32.done) resQ.push_back(getC(32));
      if (i == 0)       drive(32, 1'b1, 4'd9,  64'hF0F0,     64'h0FF0);
      else if (i == 1)  drive(32, 1'b1, 4'd10, 64'h1234,     64'h100);
      else if (i == 2)  drive(32, 1'b1, 4'd2,  64'hFF00FF00, 64'h0FF00FF0);
      else if (i == 36) drive(32, 1'b0, 4'd0,  64'd0,        64'd0);
    end
    expPat     = '0;
    expPat[0]  = 1'b1;
    expPat[1]  = 1'b1;
    expPat[35] = 1'b1;
    expPat[36] = 1'b1;
    checkOutput("b2b_done_pattern", 64'(donePat), 64'(expPat));
    checkOutput("b2b_result_count", 64'(resQ.size()), 64'd4);
    for (int i = 0; i < resQ.size() && i < 4; i++) begin
      checkOutput($sformatf("b2b_result_%0d", i), resQ[i], b2bExp[i]);
    end

    // Reset asserted mid-multiply with start high: abort, no done afterwards
    @(negedge clk);
    drive(32, 1'b1, 4'd10, 64'd7, 64'd9);
    @(posedge clk);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("mrst_C",    getC(32),           64'd0);
    checkOutput("mrst_zero", 64'(b32.zero),      64'd1);
    checkOutput("mrst_ovf",  64'(b32.overflow),  64'd0);
    checkOutput("mrst_busy", 64'(b32.busy),      64'd0);
    checkOutput("mrst_done", 64'(b32.done),      64'd0);
    reset = 1'b0;
    drive(32, 1'b0, 4'd0, 64'd0, 64'd0);
    doneCnt = 0;
    busyCyc = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.done) doneCnt++;
      if (b32.busy) busyCyc++;
    end
    checkOutput("mrst_no_done", 64'(doneCnt), 64'd0);
    checkOutput("mrst_no_busy", 64'(busyCyc), 64'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 2; i++) begin
      int w, n;
      logic [63:0] mask;
      w    = (i == 0) ? 32 : 8;
      n    = (i == 0) ? 1500 : 10000;
      mask = (64'd1 << w) - 64'd1;
      for (int j = 0; j < n; j++) begin
        op = 4'($urandom_range(0, 15));
        a  = {$urandom, $urandom} & mask;
        case ($urandom_range(0, 7))
          0:       b = 64'd0;
          1, 2:    b = 64'($urandom_range(0, 2 * w));
          default: b = {$urandom, $urandom} & mask;
        endcase
        refModel(w, op, a, b, expC, expOvf);
        expLat = isMulti(op) ? w + 1 : 0;
        applyStimulus(w, op, a, b, c, z, o, lat, busyCyc);
        checkOutput($sformatf("rnd_w%0d_op%0d_C a=%0h b=%0h", w, op, a, b), c, expC);
        checkOutput($sformatf("rnd_w%0d_op%0d_zero", w, op), 64'(z), 64'(expC == 64'd0));
        checkOutput($sformatf("rnd_w%0d_op%0d_ovf a=%0h b=%0h", w, op, a, b), 64'(o), 64'(expOvf));
        checkOutput($sformatf("rnd_w%0d_op%0d_lat", w, op), 64'(lat), 64'(expLat));
      end
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
